clk_div_cfg: RTL and testbench



---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_cfg.sv | 108 ++++++++++
 tb/tb_clk_div_cfg.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div family (divider and its config front-end).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_WIDTH_DEF = 4;
  localparam int unsigned CLK_DIV_RESET_DEF = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } clk_div_cfg_state_e;

endpackage

// File: rtl/clk_div_cfg.sv
// Divider config front-end: applies a new div value only on a period boundary of clk_div.
// Latency: change completes old+new cycles after accept; reject/no-op answer the next cycle.
// Backpressure: req_ready_o low (busy_o high) for the whole DRAIN + SETTLE window.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = CLK_DIV_WIDTH_DEF,
  parameter int unsigned DIV_RESET = CLK_DIV_RESET_DEF
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  // A zero reset divider would make the first DRAIN count wrap; reject it at elaboration.
  if (DIV_RESET == 0 || DIV_RESET >= (64'd1 << DIV_WIDTH)) begin : g_bad_div_reset
    $error("clk_div_cfg: DIV_RESET must be nonzero and fit in DIV_WIDTH bits");
  end

  localparam logic [DIV_WIDTH-1:0] DIV_RST_VAL = DIV_WIDTH'(DIV_RESET);
  localparam logic [DIV_WIDTH-1:0] ONE         = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] ZERO        = '0;

  clk_div_cfg_state_e   state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // State, counter, pending value, divider output and pulse registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      pend_q  <= ZERO;
      div_q   <= DIV_RST_VAL;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE, wait out the old period in DRAIN, one new period in SETTLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    div_d   = div_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_div_i == ZERO) begin
            err_d = 1'b1;
          end else if (req_div_i == div_q) begin
            done_d = 1'b1;
          end else begin
            // div_q is never zero here, so div_q-1 cannot wrap.
            pend_d  = req_div_i;
            cnt_d   = div_q - ONE;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q != ZERO) begin
          cnt_d = cnt_q - ONE;
        end else begin
          div_d   = pend_q;
          cnt_d   = pend_q - ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != ZERO) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign div_o       = div_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Self-checking bench for clk_div_cfg: scoreboard of expected outcomes per request.
// Latency: n/a.
// Backpressure: requests wait on req_ready_o with a bounded loop.
module tb_clk_div_cfg;
  import clk_div_pkg::*;

  localparam int W = CLK_DIV_WIDTH_DEF;

  logic         clk_i = 1'b0;
  logic         arst_ni;
  logic [W-1:0] req_div_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] div_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  clk_div_cfg #(
    .DIV_WIDTH (W),
    .DIV_RESET (CLK_DIV_RESET_DEF)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_div_i   (req_div_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .div_o       (div_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // kind: 0 = done pulse, 1 = err pulse. lat counts negedges after the accept edge.
  typedef struct {
    int           kind;
    logic [W-1:0] div;
    int           lat;
    int           busy;
    int           chg;
  } exp_t;

  exp_t         sb[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] model_div;

  // Reference model of the documented timing: O+N busy cycles, new div visible after edge O.
  task automatic push_exp(input logic [W-1:0] v);
    exp_t e;
    if (v == '0) begin
      e = '{kind: 1, div: model_div, lat: 1, busy: 0, chg: 0};
    end else if (v == model_div) begin
      e = '{kind: 0, div: model_div, lat: 1, busy: 0, chg: 0};
    end else begin
      e = '{kind: 0, div: v, lat: int'(model_div) + int'(v) + 1,
            busy: int'(model_div) + int'(v), chg: int'(model_div) + 1};
      model_div = v;
    end
    sb.push_back(e);
  endtask

  task automatic do_req(input logic [W-1:0] v, input bit hold, input logic [W-1:0] hold_val);
    exp_t         e;
    int           k;
    int           busy_cnt;
    int           chg_k;
    bit           seen;
    logic [W-1:0] prev;
    logic         o_done;
    logic         o_err;
    logic [W-1:0] o_div;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    prev = div_o;
    push_exp(v);
    req_div_i   = v;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    k = 0; busy_cnt = 0; chg_k = 0; seen = 1'b0;
    o_done = 1'b0; o_err = 1'b0; o_div = '0;
    while (!seen && k < 100) begin
      @(negedge clk_i);
      k++;
      if (hold) req_div_i = hold_val;
      else req_valid_i = 1'b0;
      if (busy_o === 1'b1) busy_cnt++;
      if (chg_k == 0 && div_o !== prev) chg_k = k;
      if (done_o === 1'b1 || err_o === 1'b1) begin
        seen = 1'b1;
        o_done = done_o; o_err = err_o; o_div = div_o;
      end
    end
    req_valid_i = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (!seen) begin
      $display("FAIL req_%0d timeout: no done/err pulse within %0d cycles", v, k);
      return;
    end
    n_pass++;
    n_chk++;
    if ((o_err ? 1 : 0) !== e.kind || (o_done && o_err)) begin
      $display("FAIL req_%0d kind: done=%b err=%b, required kind %0d (0=done,1=err)", v, o_done, o_err, e.kind);
    end else n_pass++;
    n_chk++;
    if (k !== e.lat) $display("FAIL req_%0d latency: got %0d, required %0d", v, k, e.lat);
    else n_pass++;
    n_chk++;
    if (busy_cnt !== e.busy) $display("FAIL req_%0d busy_cycles: got %0d, required %0d", v, busy_cnt, e.busy);
    else n_pass++;
    n_chk++;
    if (chg_k !== e.chg) $display("FAIL req_%0d div_change_cycle: got %0d, required %0d", v, chg_k, e.chg);
    else n_pass++;
    n_chk++;
    if (o_div !== e.div) $display("FAIL req_%0d div_o: got %0d, required %0d", v, o_div, e.div);
    else n_pass++;
    @(negedge clk_i);
    n_chk++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL req_%0d pulse_width: done=%b err=%b ready=%b, required 0 0 1", v, done_o, err_o, req_ready_o);
    end else n_pass++;
  endtask

  task automatic test_reset();
    arst_ni     = 1'b0;
    req_valid_i = 1'b0;
    req_div_i   = '0;
    repeat (5) @(negedge clk_i);
    n_chk++;
    if (div_o !== W'(CLK_DIV_RESET_DEF) || req_ready_o !== 1'b1 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || err_o !== 1'b0) begin
      $display("FAIL reset_state: div=%0d ready=%b busy=%b done=%b err=%b, required 1 1 0 0 0",
               div_o, req_ready_o, busy_o, done_o, err_o);
    end else n_pass++;
    arst_ni   = 1'b1;
    model_div = W'(CLK_DIV_RESET_DEF);
    @(negedge clk_i);
    n_chk++;
    if (div_o !== W'(CLK_DIV_RESET_DEF) || req_ready_o !== 1'b1) begin
      $display("FAIL post_reset_idle: div=%0d ready=%b, required 1 1", div_o, req_ready_o);
    end else n_pass++;
  endtask

  task automatic test_change_1_3();
    do_req(W'(3), 1'b0, '0);
  endtask

  task automatic test_change_15_2_then_0();
    do_req(W'(15), 1'b0, '0);
    do_req(W'(2), 1'b0, '0);
    do_req(W'(0), 1'b0, '0);
  endtask

  task automatic test_same_and_hold();
    do_req(W'(2), 1'b0, '0);
    // Valid stays high with a different value while busy; it must not leak into div_o.
    do_req(W'(5), 1'b1, W'(7));
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    do_req(W'(1), 1'b0, '0);
    req_div_i   = W'(15);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    n_chk++;
    if (busy_o !== 1'b1 || div_o !== W'(15)) begin
      $display("FAIL mid_settle: busy=%b div=%0d, required 1 15", busy_o, div_o);
    end else n_pass++;
    #2 arst_ni = 1'b0;
    #1;
    n_chk++;
    if (div_o !== W'(CLK_DIV_RESET_DEF) || req_ready_o !== 1'b1 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || err_o !== 1'b0) begin
      $display("FAIL async_reset: div=%0d ready=%b busy=%b done=%b err=%b, required 1 1 0 0 0",
               div_o, req_ready_o, busy_o, done_o, err_o);
    end else n_pass++;
    repeat (2) @(negedge clk_i);
    arst_ni   = 1'b1;
    model_div = W'(CLK_DIV_RESET_DEF);
    saw_done  = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o === 1'b1 || err_o === 1'b1) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done || div_o !== W'(CLK_DIV_RESET_DEF)) begin
      $display("FAIL reset_discard: pulse_seen=%b div=%0d, required 0 1", saw_done, div_o);
    end else n_pass++;
  endtask

  task automatic test_sweep();
    for (int v = 1; v <= 15; v++) do_req(W'(v), 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_change_1_3();
    test_change_15_2_then_0();
    test_same_and_hold();
    test_reset_mid();
    test_sweep();
    n_chk++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
